// File: rtl/adc_fifo_frame_reader.sv
// -----------------------------------------------------------------------------
// adc_fifo_frame_reader
//
// Drains the read side of the ADC sample FIFO in fixed-length frames and
// presents them to the FFT input stage as a valid/ready stream with a
// last-beat marker. A frame is only started once FRAME_LEN samples are
// buffered. Reads are then burst through a 4-entry skid buffer. Reads are
// issued only against free skid credit, so downstream backpressure can never
// drop a sample.
//
// Build option:
//   ADC_RD_OFFSET_BIN_EN - when defined, the sample MSB is inverted on entry
//                          to the skid buffer (offset binary -> two's
//                          complement). Timing is identical either way.
//
// Ports:
//   rd_clk_i          sole clock (FIFO read domain)
//   rd_rst_n_i        asynchronous active-low reset
//   frame_req_i       level; while high, frames are captured back-to-back
//   rd_en_o           FIFO read enable
//   rd_data_i         FIFO read data, valid RD_LATENCY cycles after rd_en_o
//   rd_empty_i        FIFO empty
//   rd_water_level_i  FIFO occupancy
//   m_data_o          sample out (skid head)
//   m_valid_o         sample valid
//   m_ready_i         downstream accept
//   m_last_o          final sample of the frame
//   frame_done_o      one-cycle pulse when the last beat is accepted
//   underrun_o        sticky; FIFO went empty while reads were still owed
//
// States:
//   state     | meaning
//   IDLE      | no frame in progress, waiting for frame_req_i
//   WAIT_FILL | counters cleared, waiting for a full frame in the FIFO
//   BURST     | issuing reads until FRAME_LEN have been issued
//   DRAIN     | all reads issued, emptying skid until the last beat is taken
// -----------------------------------------------------------------------------
module adc_fifo_frame_reader #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WIDTH = 10,
  parameter int FRAME_LEN   = 1024,
  parameter int RD_LATENCY  = 1
) (
  input  logic                  rd_clk_i,
  input  logic                  rd_rst_n_i,
  input  logic                  frame_req_i,
  output logic                  rd_en_o,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  input  logic                  rd_empty_i,
  input  logic [DEPTH_WIDTH:0]  rd_water_level_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic                  m_last_o,
  output logic                  frame_done_o,
  output logic                  underrun_o
);

  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  localparam logic [CNT_W-1:0]     FRAME_CNT = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0]     LAST_IDX  = CNT_W'(FRAME_LEN - 1);
  localparam logic [DEPTH_WIDTH:0] FILL_LVL  = (DEPTH_WIDTH + 1)'(FRAME_LEN);

`ifdef ADC_RD_OFFSET_BIN_EN
  localparam logic [DATA_WIDTH-1:0] DATA_XOR = {1'b1, {(DATA_WIDTH-1){1'b0}}};
`else
  localparam logic [DATA_WIDTH-1:0] DATA_XOR = '0;
`endif

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_FILL = 2'd1,
    BURST     = 2'd2,
    DRAIN     = 2'd3
  } state_t;

  state_t                state_q;
  logic [CNT_W-1:0]      issued_q;
  logic [CNT_W-1:0]      sent_q;
  logic                  underrun_q;

  // Read-return tracking: bit i set means a read issued i+1 cycles ago.
  logic [RD_LATENCY-1:0] infl_q;
  logic [RD_LATENCY-1:0] infl_last_q;

  logic [DATA_WIDTH-1:0] skid_data_q [4];
  logic [3:0]            skid_last_q;
  logic [1:0]            wr_ptr_q, wr_ptr_d;
  logic [1:0]            rd_ptr_q, rd_ptr_d;
  logic [2:0]            occ_q, occ_d;

  logic [2:0]            infl_cnt;
  logic                  issue_open;
  logic                  issue_last;
  logic                  credit_ok;
  logic                  push;
  logic                  push_last;
  logic                  pop;

  always_comb begin
    infl_cnt = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      infl_cnt = infl_cnt + {2'b00, infl_q[i]};
    end
  end

  assign issue_open = (issued_q < FRAME_CNT);
  assign issue_last = (issued_q == LAST_IDX);
  // Every outstanding read already owns a skid slot; m_ready_i is kept out of
  // this path so a same-cycle pop only frees its credit on the next cycle.
  assign credit_ok  = ((occ_q + infl_cnt) < 3'd4);
  assign rd_en_o    = (state_q == BURST) & ~rd_empty_i & issue_open & credit_ok;

  assign push      = infl_q[RD_LATENCY-1];
  assign push_last = infl_last_q[RD_LATENCY-1];

  assign m_valid_o    = (occ_q != 3'd0);
  assign m_data_o     = skid_data_q[rd_ptr_q];
  assign m_last_o     = m_valid_o & skid_last_q[rd_ptr_q];
  assign pop          = m_valid_o & m_ready_i;
  assign frame_done_o = pop & m_last_o;
  assign underrun_o   = underrun_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + {1'b0, push};
    rd_ptr_d = rd_ptr_q + {1'b0, pop};
    occ_d    = occ_q + {2'b00, push} - {2'b00, pop};
  end

  always_ff @(posedge rd_clk_i or negedge rd_rst_n_i) begin
    if (!rd_rst_n_i) begin
      state_q    <= IDLE;
      issued_q   <= '0;
      sent_q     <= '0;
      underrun_q <= 1'b0;
    end else begin
      if (rd_en_o) issued_q <= issued_q + CNT_W'(1);
      if (pop)     sent_q   <= sent_q + CNT_W'(1);
      if ((state_q == BURST) && rd_empty_i && issue_open) underrun_q <= 1'b1;

      unique case (state_q)
        IDLE: begin
          if (frame_req_i) begin
            state_q  <= WAIT_FILL;
            issued_q <= '0;
            sent_q   <= '0;
          end
        end
        WAIT_FILL: begin
          if (rd_water_level_i >= FILL_LVL) state_q <= BURST;
        end
        BURST: begin
          if (!issue_open) state_q <= DRAIN;
        end
        DRAIN: begin
          // The issue-time tag and the accepted-beat count must agree before
          // the frame is closed.
          if (frame_done_o && (sent_q == LAST_IDX)) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge rd_clk_i or negedge rd_rst_n_i) begin
    if (!rd_rst_n_i) begin
      infl_q      <= '0;
      infl_last_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      skid_last_q <= '0;
      for (int i = 0; i < 4; i++) skid_data_q[i] <= '0;
    end else begin
      infl_q[0]      <= rd_en_o;
      infl_last_q[0] <= issue_last;
      for (int i = 1; i < RD_LATENCY; i++) begin
        infl_q[i]      <= infl_q[i-1];
        infl_last_q[i] <= infl_last_q[i-1];
      end
      if (push) begin
        skid_data_q[wr_ptr_q] <= rd_data_i ^ DATA_XOR;
        skid_last_q[wr_ptr_q] <= push_last;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

endmodule

// File: tb/tb_adc_fifo_frame_reader.sv
// Two instances share one clock and reset: u_dut0 with RD_LATENCY=1 and
// u_dut1 with RD_LATENCY=2, both FRAME_LEN=16 and 8-bit data. Each has its
// own FIFO model. Loading a sample pushes its expected output beat into that
// instance's scoreboard queue. A negedge monitor pops and compares every
// accepted beat.
module tb_adc_fifo_frame_reader;
  localparam int DW  = 8;
  localparam int DPW = 6;
  localparam int FL  = 16;

`ifdef ADC_RD_OFFSET_BIN_EN
  localparam logic [7:0] MASK = 8'h80;
  localparam logic [7:0] E80  = 8'h00;
  localparam logic [7:0] E7F  = 8'hFF;
`else
  localparam logic [7:0] MASK = 8'h00;
  localparam logic [7:0] E80  = 8'h80;
  localparam logic [7:0] E7F  = 8'h7F;
`endif

  logic       clk, rst_n;
  logic [1:0] frame_req, rd_en, rd_empty, m_valid, m_ready, m_last, frame_done, underrun;
  logic [1:0] force_empty, wr_v, flush;
  logic [7:0] rd_data [2];
  logic [7:0] m_data  [2];
  logic [7:0] wr_d    [2];
  logic [6:0] water   [2];
  logic [7:0] s1;
  logic [7:0] mem [2][64];
  int         head [2];
  int         tail [2];
  bit         rnd_on;

  logic [8:0] exp_q [2][$];
  logic [8:0] e;
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int first_en  [2] = '{-1, -1};
  int first_v   [2] = '{-1, -1};
  int acc_cnt   [2] = '{0, 0};
  int fd_cnt    [2] = '{0, 0};
  int beat_idx  [2] = '{0, 0};
  int beat_cyc0 [2] = '{0, 0};
  int beat_cycl [2] = '{0, 0};
  bit stall_v   [2] = '{0, 0};
  logic [7:0] stall_d [2];
  int max_occ = 0;

  adc_fifo_frame_reader #(.DATA_WIDTH(DW), .DEPTH_WIDTH(DPW), .FRAME_LEN(FL), .RD_LATENCY(1)) u_dut0 (
    .rd_clk_i(clk), .rd_rst_n_i(rst_n), .frame_req_i(frame_req[0]), .rd_en_o(rd_en[0]),
    .rd_data_i(rd_data[0]), .rd_empty_i(rd_empty[0]), .rd_water_level_i(water[0]),
    .m_data_o(m_data[0]), .m_valid_o(m_valid[0]), .m_ready_i(m_ready[0]), .m_last_o(m_last[0]),
    .frame_done_o(frame_done[0]), .underrun_o(underrun[0]));

  adc_fifo_frame_reader #(.DATA_WIDTH(DW), .DEPTH_WIDTH(DPW), .FRAME_LEN(FL), .RD_LATENCY(2)) u_dut1 (
    .rd_clk_i(clk), .rd_rst_n_i(rst_n), .frame_req_i(frame_req[1]), .rd_en_o(rd_en[1]),
    .rd_data_i(rd_data[1]), .rd_empty_i(rd_empty[1]), .rd_water_level_i(water[1]),
    .m_data_o(m_data[1]), .m_valid_o(m_valid[1]), .m_ready_i(m_ready[1]), .m_last_o(m_last[1]),
    .frame_done_o(frame_done[1]), .underrun_o(underrun[1]));

  assign rd_empty[0] = (head[0] == tail[0]) | force_empty[0];
  assign rd_empty[1] = (head[1] == tail[1]) | force_empty[1];
  assign water[0]    = 7'(tail[0] - head[0]);
  assign water[1]    = 7'(tail[1] - head[1]);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO models: RD_LATENCY=1 for instance 0, 2 for instance 1.
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (flush[k]) begin
        head[k] <= 0;
        tail[k] <= 0;
      end else begin
        if (wr_v[k]) begin
          mem[k][tail[k] % 64] <= wr_d[k];
          tail[k] <= tail[k] + 1;
        end
        if (rd_en[k]) head[k] <= head[k] + 1;
      end
    end
    if (rd_en[0]) rd_data[0] <= mem[0][head[0] % 64];
    if (rd_en[1]) s1 <= mem[1][head[1] % 64];
    rd_data[1] <= s1;
  end

  initial begin
    m_ready = 2'b11;
    forever begin
      @(posedge clk);
      #1;
      m_ready = {(rnd_on ? 1'($urandom_range(0, 1)) : 1'b1), 1'b1};
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (int'(u_dut1.occ_q) > max_occ) max_occ = int'(u_dut1.occ_q);
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        stall_v[k] = 1'b0;
      end else begin
        if (rd_en[k] && first_en[k] < 0) first_en[k] = cyc;
        if (m_valid[k] && first_v[k] < 0) first_v[k] = cyc;
        if (stall_v[k]) check("stall_hold", {m_valid[k], m_data[k]}, {1'b1, stall_d[k]});
        if (m_valid[k] && m_ready[k]) begin
          if (exp_q[k].size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_beat dut%0d: got data %0h with none expected", k, m_data[k]);
          end else begin
            e = exp_q[k].pop_front();
            check("beat_last_data", {m_last[k], m_data[k]}, e);
            check("frame_done_on_beat", frame_done[k], e[8]);
            if (beat_idx[k] == 0) beat_cyc0[k] = cyc;
            if (e[8]) begin
              beat_cycl[k] = cyc;
              beat_idx[k]  = 0;
            end else begin
              beat_idx[k]++;
            end
            acc_cnt[k]++;
          end
        end else if (frame_done[k]) begin
          n_tests++;
          n_fail++;
          $display("FAIL spurious_done dut%0d: got frame_done=1 required 0 without accept", k);
        end
        if (frame_done[k]) fd_cnt[k]++;
        stall_v[k] = m_valid[k] & ~m_ready[k];
        stall_d[k] = m_data[k];
      end
    end
  end

  task automatic load(input int k, input logic [7:0] d, input logic [7:0] ev, input bit last);
    @(negedge clk);
    wr_v[k] = 1'b1;
    wr_d[k] = d;
    exp_q[k].push_back({last, ev});
  endtask

  task automatic load_end(input int k);
    @(negedge clk);
    wr_v[k] = 1'b0;
  endtask

  task automatic load_frame(input int k, input logic [7:0] base);
    for (int i = 0; i < FL; i++) load(k, base + 8'(i), (base + 8'(i)) ^ MASK, i == FL - 1);
    load_end(k);
  endtask

  task automatic pulse_req(input int k);
    frame_req[k] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    frame_req[k] = 1'b0;
  endtask

  task automatic wait_done(input int k, input int target, input int budget, input string name);
    int n = 0;
    while (fd_cnt[k] < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(name, fd_cnt[k], target);
  endtask

  task automatic wait_acc(input int k, input int target, input int budget, input string name);
    int n = 0;
    while (acc_cnt[k] < target && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(name, acc_cnt[k], target);
  endtask

  initial begin
    int base;
    rst_n = 1'b0; frame_req = '0; force_empty = '0; wr_v = '0; flush = '0; rnd_on = 1'b0;
    wr_d[0] = '0; wr_d[1] = '0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs_dut0", {rd_en[0], m_valid[0], m_last[0], frame_done[0], underrun[0], m_data[0]}, 0);
    check("reset_outputs_dut1", {rd_en[1], m_valid[1], m_last[1], frame_done[1], underrun[1], m_data[1]}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Level 15 holds WAIT_FILL; the 16th sample releases BURST one cycle later.
    for (int i = 0; i < FL - 1; i++) load(0, 8'(i), 8'(i) ^ MASK, 1'b0);
    load_end(0);
    frame_req[0] = 1'b1;
    repeat (5) begin
      @(negedge clk);
      #1;
      check("wait_fill_rd_en_low", {rd_en[0], m_valid[0]}, 0);
    end
    load(0, 8'd15, 8'd15 ^ MASK, 1'b1);
    load_end(0);
    #1;
    check("fill_cycle_rd_en_low", rd_en[0], 0);
    @(negedge clk);
    #1;
    check("burst_first_rd_en", rd_en[0], 1);
    frame_req[0] = 1'b0;
    wait_done(0, 1, 100, "frame1_done");
    check("first_valid_latency_l1", first_v[0] - first_en[0], 2);
    check("throughput_l1", beat_cycl[0] - beat_cyc0[0], FL - 1);
    check("no_underrun_yet", underrun[0], 0);
    repeat (4) @(negedge clk);
    #1;
    check("single_done_pulse", fd_cnt[0], 1);

    // RD_LATENCY=2 under random backpressure, including offset-binary codes.
    rnd_on = 1'b1;
    load(1, 8'h80, E80, 1'b0);
    load(1, 8'h7F, E7F, 1'b0);
    for (int i = 2; i < FL; i++) load(1, 8'h30 + 8'(i), (8'h30 + 8'(i)) ^ MASK, i == FL - 1);
    load_end(1);
    pulse_req(1);
    wait_done(1, 1, 600, "frame_l2_random_done");
    check("first_valid_latency_l2", first_v[1] - first_en[1], 3);
    rnd_on = 1'b0;
    load_frame(1, 8'h50);
    pulse_req(1);
    wait_done(1, 2, 200, "frame_l2_full_rate_done");
    check("throughput_l2", beat_cycl[1] - beat_cyc0[1], FL - 1);
    check("skid_occ_over_4", max_occ > 4, 0);

    // FIFO forced empty mid-burst.
    base = acc_cnt[0];
    load_frame(0, 8'h20);
    pulse_req(0);
    wait_acc(0, base + 4, 100, "reach_mid_burst");
    force_empty[0] = 1'b1;
    #1;
    check("rd_en_low_while_empty", rd_en[0], 0);
    repeat (2) begin
      @(negedge clk);
      #1;
      check("rd_en_low_while_empty", rd_en[0], 0);
    end
    @(negedge clk);
    force_empty[0] = 1'b0;
    #1;
    check("underrun_set", underrun[0], 1);
    wait_done(0, 2, 200, "underrun_frame_done");
    check("underrun_sticky", underrun[0], 1);

    // Reset at beat 7, then a clean frame.
    base = acc_cnt[0];
    load_frame(0, 8'h40);
    pulse_req(0);
    wait_acc(0, base + 7, 100, "reach_beat7");
    rst_n = 1'b0;
    #1;
    check("mid_frame_reset_outputs", {rd_en[0], m_valid[0], m_last[0], frame_done[0], underrun[0], m_data[0]}, 0);
    flush[0] = 1'b1;
    exp_q[0].delete();
    beat_idx[0] = 0;
    @(negedge clk);
    @(negedge clk);
    flush[0] = 1'b0;
    rst_n = 1'b1;
    load_frame(0, 8'h60);
    pulse_req(0);
    wait_done(0, 3, 200, "post_reset_frame_done");

    check("scoreboard_empty_dut0", exp_q[0].size(), 0);
    check("scoreboard_empty_dut1", exp_q[1].size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/adc_fifo_frame_reader.md
# adc_fifo_frame_reader

- Drains the read side of the ADC sample FIFO in fixed-length frames and presents them as a valid/ready stream with frame markers to the FFT input stage.
- Waits until one full frame is buffered, then bursts reads through a 4-entry skid buffer so downstream backpressure never loses a sample.
- Sits between the ADC FIFO (read port) and the FFT core, in the read clock domain.

## Interface
- `DATA_WIDTH`, 32, FIFO read data width.
- `DEPTH_WIDTH`, 10, FIFO read address width; `rd_water_level` is `DEPTH_WIDTH+1` bits.
- `FRAME_LEN`, 1024, samples per frame; legal range 1..2^DEPTH_WIDTH.
- `RD_LATENCY`, 1, cycles from `rd_en` to valid `rd_data`; legal values 1 or 2 (2 when the FIFO output register is enabled).
- `rd_clk`, in, 1, sole clock.
- `rd_rst_n`, in, 1, asynchronous active-low reset.
- `frame_req`, in, 1, level; while high, frames are captured back-to-back.
- `rd_en`, out, 1, FIFO read enable.
- `rd_data`, in, DATA_WIDTH, FIFO read data.
- `rd_empty`, in, 1, FIFO empty.
- `rd_water_level`, in, DEPTH_WIDTH+1, FIFO occupancy.
- `m_data`, out, DATA_WIDTH, sample out.
- `m_valid`, out, 1, sample valid.
- `m_ready`, in, 1, downstream accept.
- `m_last`, out, 1, final sample of the frame.
- `frame_done`, out, 1, one-cycle pulse when the last beat is accepted.
- `underrun`, out, 1, sticky; set if `rd_empty` is seen while reads are still owed.

## Operation
- States:
  - IDLE -> WAIT_FILL when `frame_req`=1.
  - WAIT_FILL -> BURST when `rd_water_level >= FRAME_LEN`.
  - BURST -> DRAIN when issued count = FRAME_LEN.
  - DRAIN -> IDLE on accepted beat with `m_last`, pulsing `frame_done` the same cycle.
- `frame_req` deasserting mid-frame has no effect; the frame always completes.
- `rd_en = (state==BURST) & !rd_empty & (issued < FRAME_LEN) & (occ + inflight < 4)`.
  - The expression is built from registered terms only; there is no combinational path from `m_ready`.
  - A pop in the same cycle frees its credit on the next cycle.
- `inflight` is a RD_LATENCY-deep shift register of `rd_en`. Its output pushes `rd_data` into the skid buffer.
- Skid buffer: 4 entries, 2-bit read and write pointers, 3-bit occupancy.
  - Push and pop in the same cycle leave occupancy unchanged.
  - Pointers wrap 3 -> 0.
- `m_data`, `m_valid`, `m_last` come from the skid head.
  - `m_last` is high when the head entry's beat index = FRAME_LEN-1.
  - A per-entry last flag is tagged at issue time from the issue counter.
- Counters are `$clog2(FRAME_LEN+1)` bits: `issued` counts reads issued, `sent` counts beats accepted. Both clear on entering WAIT_FILL.
- `underrun` sets in BURST when `rd_empty`=1 and issued < FRAME_LEN. Reading stalls until data returns, then resumes. The flag is cleared only by reset.
- Reset, mid-frame or otherwise:
  - State returns to IDLE; counters, pointers and inflight are cleared.
  - Skid contents are discarded.
  - The FIFO is not flushed by this block.

## Timing
- All outputs reset to 0.
- `frame_req` rising in IDLE gives WAIT_FILL on the next cycle.
- The fill condition true gives BURST on the next cycle; `rd_en` may be high in that first BURST cycle.
- First `m_valid` arrives RD_LATENCY+1 cycles after the first `rd_en`.
- With `m_ready`=1 throughout, throughput is 1 sample/cycle for RD_LATENCY up to 2. A frame spans FRAME_LEN+RD_LATENCY+1 cycles from first `rd_en` to `frame_done`.
- `m_valid` and `m_data` stay stable while `m_valid & !m_ready`.
- Back-to-back frames: after `frame_done` there is at least 2 idle cycles (IDLE, WAIT_FILL) before the next `rd_en`.

## Configuration
- `ADC_RD_OFFSET_BIN_EN`
  - Defined: the MSB of each sample is inverted on entry to the skid buffer, converting offset-binary ADC codes to two's complement for the FFT.
  - Undefined: data passes unmodified.
- Latency and timing are identical either way.

## Test plan
- FRAME_LEN=16, RD_LATENCY=1, `m_ready`=1, FIFO preloaded with 0..15:
  - `m_data` is 0..15 on consecutive cycles.
  - `m_last` is high with 15.
  - `frame_done` pulses once.
  - First `m_valid` is 2 cycles after first `rd_en`.
- RD_LATENCY=2, `m_ready` toggling randomly:
  - There is no loss or duplication.
  - Skid occupancy never exceeds 4.
  - `m_data` holds while stalled.
- Water level at 15 with FRAME_LEN=16: the block stays in WAIT_FILL with `rd_en`=0. At level 16, BURST is entered the next cycle.
- Force `rd_empty`=1 for 3 cycles mid-BURST:
  - `underrun` goes to 1 and stays.
  - `rd_en` stays low while empty.
  - All 16 samples are still delivered.
- Assert `rd_rst_n`=0 at beat 7:
  - All outputs are 0 immediately.
  - After release, a new `frame_req` yields a clean frame starting at its first beat.
- With `ADC_RD_OFFSET_BIN_EN` defined and DATA_WIDTH=8, input 8'h80 produces `m_data`=8'h00 and 8'h7F produces 8'hFF.
